// File: rtl/tpu_pac_ras_pkg.sv
// Shared types and defaults for the TPU program-address controller with
// return-address stack.
package tpu_pac_ras_pkg;

    localparam int PAC_ADDR_W_DEF    = 16;
    localparam int PAC_RAS_DEPTH_DEF = 8;

    typedef logic [PAC_ADDR_W_DEF-1:0] pac_addr_t;

    typedef enum logic [1:0] {
        PAC_IDLE = 2'd0,
        PAC_RUN  = 2'd1,
        PAC_WAIT = 2'd2
    } pac_state_t;

endpackage

// File: rtl/tpu_pac_ras_stack.sv
// Return-address LIFO with push/pop/flush and occupancy tracking.
// TPU_PAC_RAS_PROTECT_EN: when defined, a push into a full stack is dropped;
// otherwise it overwrites the oldest entry.
module tpu_pac_ras_stack
    import tpu_pac_ras_pkg::*;
#(
    parameter int ADDR_W    = PAC_ADDR_W_DEF,
    parameter int RAS_DEPTH = PAC_RAS_DEPTH_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [ADDR_W-1:0]          i_data,
    output logic [ADDR_W-1:0]          o_top,
    output logic [$clog2(RAS_DEPTH):0] o_depth,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic                       o_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int DEP_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_sp;
    logic [DEP_W-1:0]  r_depth;
    logic              w_full;
    logic              w_wr;

    // Status flags and write qualification.
    always_comb begin
        w_full      = (r_depth == DEP_W'(RAS_DEPTH));
        o_empty     = (r_depth == {DEP_W{1'b0}});
        o_overflow  = i_push & ~i_flush & w_full;
        o_underflow = i_pop & ~i_flush & o_empty;
        o_top       = r_mem[r_sp - PTR_W'(1)];
        o_depth     = r_depth;
`ifdef TPU_PAC_RAS_PROTECT_EN
        w_wr        = i_push & ~i_flush & ~w_full;
`else
        w_wr        = i_push & ~i_flush;
`endif
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_sp] <= i_data;
        end
    end

    // Pointer wraps on overwrite, so depth saturates while sp keeps moving.
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_sp    <= {PTR_W{1'b0}};
            r_depth <= {DEP_W{1'b0}};
        end else if (w_wr) begin
            r_sp <= r_sp + PTR_W'(1);
            if (!w_full) begin
                r_depth <= r_depth + DEP_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_sp    <= r_sp - PTR_W'(1);
            r_depth <= r_depth - DEP_W'(1);
        end
    end

endmodule

// File: rtl/tpu_pac_ras.sv
// Program-address controller: PC sequencing, jump/call/return via RAS and
// condition-wait branches. Overflow handling selected by TPU_PAC_RAS_PROTECT_EN.
module tpu_pac_ras
    import tpu_pac_ras_pkg::*;
#(
    parameter int ADDR_W    = PAC_ADDR_W_DEF,
    parameter int TIMING_W  = 6,
    parameter int NUM_COND  = 4,
    parameter int RAS_DEPTH = PAC_RAS_DEPTH_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        I_Req_St,
    input  logic                        I_Req,
    input  logic                        I_Stall,
    input  logic [$clog2(NUM_COND)-1:0] I_Sel_Cond,
    input  logic [NUM_COND-1:0]         I_CondValid,
    input  logic [NUM_COND-1:0]         I_Cond,
    input  logic                        I_Jump,
    input  logic                        I_Branch,
    input  logic                        I_Call,
    input  logic                        I_Return,
    input  logic [TIMING_W-1:0]         I_Timing_MY,
    input  logic [TIMING_W-1:0]         I_Timing_WB,
    input  logic [ADDR_W-1:0]           I_Src,
    output logic                        O_IFetch,
    output logic [ADDR_W-1:0]           O_Address,
    output logic                        O_StallReq,
    output logic [$clog2(RAS_DEPTH):0]  O_RAS_Depth,
    output logic                        O_Err
);

    localparam int SEL_W = $clog2(NUM_COND);

    pac_state_t          r_state, w_next_state;
    logic [ADDR_W-1:0]   r_pc, w_pc_next, w_pc_inc, w_ras_top;
    logic [ADDR_W-1:0]   r_wait_off;
    logic [SEL_W-1:0]    r_wait_sel;
    logic [TIMING_W-1:0] w_wb_inc;
    logic                r_ifetch, r_stall, r_err;
    logic                w_ifetch_next, w_req, w_timing_ok, w_latch;
    logic                w_sel_valid, w_sel_cond, w_wait_valid, w_wait_cond;
    logic                w_push, w_pop, w_flush, w_ras_empty, w_ovf, w_unf;

    // Request qualification, timing check and condition channel selection.
    always_comb begin
        w_req        = I_Req & ~I_Stall;
        w_pc_inc     = r_pc + ADDR_W'(1);
        w_wb_inc     = I_Timing_WB + TIMING_W'(1);
        w_timing_ok  = (I_Timing_MY == w_wb_inc);
        w_sel_valid  = 1'b0;
        w_sel_cond   = 1'b0;
        w_wait_valid = 1'b0;
        w_wait_cond  = 1'b0;
        if (int'(I_Sel_Cond) < NUM_COND) begin
            w_sel_valid = I_CondValid[I_Sel_Cond];
            w_sel_cond  = I_Cond[I_Sel_Cond];
        end else begin
            w_sel_valid = 1'b0;
            w_sel_cond  = 1'b0;
        end
        if (int'(r_wait_sel) < NUM_COND) begin
            w_wait_valid = I_CondValid[r_wait_sel];
            w_wait_cond  = I_Cond[r_wait_sel];
        end else begin
            w_wait_valid = 1'b0;
            w_wait_cond  = 1'b0;
        end
    end

    // Next state, next PC and stack control; flags resolve in priority order.
    always_comb begin
        w_next_state  = r_state;
        w_pc_next     = r_pc;
        w_ifetch_next = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        w_latch       = 1'b0;
        if (I_Req_St) begin
            w_next_state = PAC_IDLE;
            w_pc_next    = {ADDR_W{1'b0}};
            w_flush      = 1'b1;
        end else begin
            case (r_state)
                PAC_IDLE, PAC_RUN: begin
                    if (w_req) begin
                        w_next_state  = PAC_RUN;
                        w_ifetch_next = 1'b1;
                        if (I_Jump) begin
                            w_pc_next = I_Src;
                        end else if (I_Call) begin
                            w_pc_next = I_Src;
                            w_push    = 1'b1;
                        end else if (I_Return) begin
                            w_pop     = 1'b1;
                            w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top;
                        end else if (I_Branch && w_timing_ok) begin
                            if (w_sel_valid) begin
                                w_pc_next = w_sel_cond ? (r_pc + I_Src) : w_pc_inc;
                            end else begin
                                w_next_state  = PAC_WAIT;
                                w_latch       = 1'b1;
                                w_ifetch_next = 1'b0;
                            end
                        end else begin
                            w_pc_next = w_pc_inc;
                        end
                    end else begin
                        w_next_state = r_state;
                    end
                end
                PAC_WAIT: begin
                    if (w_wait_valid) begin
                        w_next_state = PAC_RUN;
                        w_pc_next    = w_wait_cond ? (r_pc + r_wait_off) : w_pc_inc;
                    end else begin
                        w_next_state = PAC_WAIT;
                    end
                end
                default: begin
                    w_next_state = PAC_IDLE;
                    w_pc_next    = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // State, PC and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= PAC_IDLE;
            r_pc       <= {ADDR_W{1'b0}};
            r_ifetch   <= 1'b0;
            r_stall    <= 1'b0;
            r_err      <= 1'b0;
            r_wait_sel <= {SEL_W{1'b0}};
            r_wait_off <= {ADDR_W{1'b0}};
        end else begin
            r_state  <= w_next_state;
            r_pc     <= w_pc_next;
            r_ifetch <= w_ifetch_next;
            r_stall  <= (w_next_state == PAC_WAIT);
            r_err    <= r_err | w_ovf | w_unf;
            if (w_latch) begin
                r_wait_sel <= I_Sel_Cond;
                r_wait_off <= I_Src;
            end
        end
    end

    tpu_pac_ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_stack (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_data      (w_pc_inc),
        .o_top       (w_ras_top),
        .o_depth     (O_RAS_Depth),
        .o_empty     (w_ras_empty),
        .o_overflow  (w_ovf),
        .o_underflow (w_unf)
    );

    assign O_IFetch   = r_ifetch;
    assign O_Address  = r_pc;
    assign O_StallReq = r_stall;
    assign O_Err      = r_err;

endmodule

// File: tb/tb_tpu_pac_ras.sv
// Bench for tpu_pac_ras: directed scenarios then random flags, compared
// against a queue-based program-counter model.
module tb_tpu_pac_ras;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req_st, i_req, i_stall, i_jump, i_branch, i_call, i_return;
    logic [1:0]  i_sel;
    logic [3:0]  i_cv, i_cond;
    logic [5:0]  i_my, i_wb;
    logic [15:0] i_src;
    logic        o_ifetch, o_stallreq, o_err;
    logic [15:0] o_address;
    logic [3:0]  o_depth;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_pc;
    bit m_wait;
    int m_wsel;
    int m_woff;
    bit m_err;
    bit m_fetch;
    int m_ras[$];

    tpu_pac_ras dut (
        .clock       (clock),
        .reset       (reset),
        .I_Req_St    (i_req_st),
        .I_Req       (i_req),
        .I_Stall     (i_stall),
        .I_Sel_Cond  (i_sel),
        .I_CondValid (i_cv),
        .I_Cond      (i_cond),
        .I_Jump      (i_jump),
        .I_Branch    (i_branch),
        .I_Call      (i_call),
        .I_Return    (i_return),
        .I_Timing_MY (i_my),
        .I_Timing_WB (i_wb),
        .I_Src       (i_src),
        .O_IFetch    (o_ifetch),
        .O_Address   (o_address),
        .O_StallReq  (o_stallreq),
        .O_RAS_Depth (o_depth),
        .O_Err       (o_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        i_req_st = 1'b0; i_req = 1'b0; i_stall = 1'b0; i_jump = 1'b0;
        i_branch = 1'b0; i_call = 1'b0; i_return = 1'b0;
        i_sel = 2'd0; i_cv = 4'd0; i_cond = 4'd0;
        i_my = 6'd0; i_wb = 6'd0; i_src = 16'd0;
    endtask

    // One clock of the architectural rules applied to the current inputs.
    function automatic void model_step();
        bit req;
        bit tok;
        req     = i_req && !i_stall;
        tok     = (((int'(i_wb) + 1) % 64) == int'(i_my));
        m_fetch = 1'b0;
        if (i_req_st) begin
            m_pc   = 0;
            m_wait = 1'b0;
            m_ras.delete();
        end else if (m_wait) begin
            if (i_cv[m_wsel]) begin
                m_pc   = i_cond[m_wsel] ? (m_pc + m_woff) : (m_pc + 1);
                m_wait = 1'b0;
            end
        end else if (req) begin
            m_fetch = 1'b1;
            if (i_jump) begin
                m_pc = int'(i_src);
            end else if (i_call) begin
                if (m_ras.size() == 8) begin
                    m_err = 1'b1;
`ifndef TPU_PAC_RAS_PROTECT_EN
                    void'(m_ras.pop_front());
                    m_ras.push_back((m_pc + 1) & 32'hFFFF);
`endif
                end else begin
                    m_ras.push_back((m_pc + 1) & 32'hFFFF);
                end
                m_pc = int'(i_src);
            end else if (i_return) begin
                if (m_ras.size() == 0) begin
                    m_err = 1'b1;
                    m_pc  = m_pc + 1;
                end else begin
                    m_pc = m_ras.pop_back();
                end
            end else if (i_branch && tok) begin
                if (i_cv[i_sel]) begin
                    m_pc = i_cond[i_sel] ? (m_pc + int'(i_src)) : (m_pc + 1);
                end else begin
                    m_wait  = 1'b1;
                    m_wsel  = int'(i_sel);
                    m_woff  = int'(i_src);
                    m_fetch = 1'b0;
                end
            end else begin
                m_pc = m_pc + 1;
            end
        end
        m_pc = m_pc & 32'hFFFF;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  32'(o_address),  32'(m_pc));
        chk({tag, ".fetch"}, 32'(o_ifetch),   32'(m_fetch));
        chk({tag, ".stall"}, 32'(o_stallreq), 32'(m_wait));
        chk({tag, ".depth"}, 32'(o_depth),    32'(m_ras.size()));
        chk({tag, ".err"},   32'(o_err),      32'(m_err));
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic do_jump(input logic [15:0] tgt);
        clr(); i_req = 1'b1; i_jump = 1'b1; i_src = tgt;
        cyc("jump");
    endtask

    initial begin
        clr();
        reset = 1'b1;
        m_pc = 0; m_wait = 1'b0; m_wsel = 0; m_woff = 0; m_err = 1'b0; m_fetch = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset = 1'b0;

        // idle with no request holds
        cyc("idle_hold");

        // sequential fetch 1..4
        i_req = 1'b1;
        for (int k = 0; k < 4; k++) cyc("seq");
        chk("seq_end_pc", 32'(o_address), 32'h4);

        // stalled request is ignored
        clr(); i_req = 1'b1; i_stall = 1'b1; i_jump = 1'b1; i_src = 16'h1234;
        cyc("stall");

        // immediate taken branch 0x10 + 0x20
        do_jump(16'h0010);
        clr(); i_req = 1'b1; i_branch = 1'b1; i_my = 6'd5; i_wb = 6'd4;
        i_sel = 2'd2; i_cv = 4'b0100; i_cond = 4'b0100; i_src = 16'h0020;
        cyc("br_now");
        chk("br_now_pc", 32'(o_address), 32'h30);

        // branch waits three cycles on channel 1, resolves not-taken
        do_jump(16'h0010);
        clr(); i_req = 1'b1; i_branch = 1'b1; i_my = 6'd5; i_wb = 6'd4;
        i_sel = 2'd1; i_cv = 4'b0001; i_src = 16'h0040;
        cyc("br_wait0");
        chk("br_wait_stall", 32'(o_stallreq), 32'h1);
        clr(); i_req = 1'b1;
        cyc("br_wait1");
        cyc("br_wait2");
        i_cv = 4'b0010; i_cond = 4'b0000;
        cyc("br_resolve");
        chk("br_resolve_pc", 32'(o_address), 32'h11);

        // wrong issue number: sequential
        clr(); i_req = 1'b1; i_branch = 1'b1; i_my = 6'd7; i_wb = 6'd4;
        i_cv = 4'b1111; i_cond = 4'b1111; i_src = 16'h0100;
        cyc("br_badtime");

        // timing wrap 63+1 -> 0 and address wrap
        do_jump(16'hFFF0);
        clr(); i_req = 1'b1; i_branch = 1'b1; i_my = 6'd0; i_wb = 6'd63;
        i_sel = 2'd3; i_cv = 4'b1000; i_cond = 4'b1000; i_src = 16'h0020;
        cyc("br_wrap");
        do_jump(16'hFFFF);
        clr(); i_req = 1'b1;
        cyc("pc_wrap");
        chk("pc_wrap_pc", 32'(o_address), 32'h0);

        // call / return
        do_jump(16'h0008);
        clr(); i_req = 1'b1; i_call = 1'b1; i_src = 16'h0100;
        cyc("call");
        chk("call_depth", 32'(o_depth), 32'h1);
        clr(); i_req = 1'b1; i_return = 1'b1;
        cyc("ret");
        chk("ret_pc", 32'(o_address), 32'h9);

        // nine calls overflow, then drain plus one underflow
        do_jump(16'h0200);
        for (int k = 0; k < 9; k++) begin
            clr(); i_req = 1'b1; i_call = 1'b1; i_src = 16'(16'h0300 + 16 * k);
            cyc("ovf_call");
        end
        chk("ovf_err", 32'(o_err), 32'h1);
        for (int k = 0; k < 9; k++) begin
            clr(); i_req = 1'b1; i_return = 1'b1;
            cyc("ovf_ret");
        end

        // program-store abort while waiting
        clr(); i_req = 1'b1; i_call = 1'b1; i_src = 16'h0050;
        cyc("abort_call");
        clr(); i_req = 1'b1; i_branch = 1'b1; i_my = 6'd2; i_wb = 6'd1; i_sel = 2'd3;
        cyc("abort_wait");
        clr(); i_req_st = 1'b1;
        cyc("abort");
        chk("abort_depth", 32'(o_depth), 32'h0);
        clr(); i_req = 1'b1;
        cyc("after_abort");
        chk("after_abort_pc", 32'(o_address), 32'h1);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            clr();
            i_req    = ($urandom % 8) != 0;
            i_stall  = ($urandom % 8) == 0;
            i_req_st = ($urandom % 60) == 0;
            i_jump   = ($urandom % 10) == 0;
            i_call   = ($urandom % 7) == 0;
            i_return = ($urandom % 7) == 0;
            i_branch = ($urandom % 3) == 0;
            i_sel    = 2'($urandom_range(0, 3));
            i_cv     = 4'($urandom_range(0, 15));
            i_cond   = 4'($urandom_range(0, 15));
            i_wb     = 6'($urandom_range(0, 63));
            i_my     = (($urandom % 2) == 0) ? 6'(i_wb + 6'd1) : 6'($urandom_range(0, 63));
            i_src    = 16'($urandom_range(0, 65535));
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tpu_pac_ras.md
Name: tpu_pac_ras

Overview:
Parametrised program-address controller for the TPU scalar unit back-end, placed after the network stage and driving instruction fetch.
- Generalises the single-channel PC unit to NUM_COND selectable condition channels and configurable address and timing widths.
- Adds call/return through a hardware return-address stack (RAS) of depth RAS_DEPTH.
- Adds an explicit IDLE/RUN/WAIT state machine that holds the PC while a branch waits for its condition.

Parameters:
ADDR_W, 16, program address width
TIMING_W, 6, issue-number width for I_Timing_MY/I_Timing_WB
NUM_COND, 4, condition channels (minimum 2)
RAS_DEPTH, 8, return-address stack entries (power of two)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
I_Req_St  in  1  program-store request: PC to 0, enter IDLE
I_Req  in  1  execute request from network stage
I_Stall  in  1  force stall; request ignored this cycle
I_Sel_Cond  in  $clog2(NUM_COND)  condition channel select
I_CondValid  in  NUM_COND  per-channel condition-valid strobe
I_Cond  in  NUM_COND  per-channel condition value
I_Jump  in  1  absolute jump to I_Src
I_Branch  in  1  conditional relative branch, PC+I_Src
I_Call  in  1  push PC+1, jump to I_Src
I_Return  in  1  pop RAS into PC
I_Timing_MY  in  TIMING_W  issue number of this instruction
I_Timing_WB  in  TIMING_W  issue number of the evaluating instruction
I_Src  in  ADDR_W  target or offset
O_IFetch  out  1  fetch request
O_Address  out  ADDR_W  program counter
O_StallReq  out  1  stall pipeline, waiting on condition
O_RAS_Depth  out  $clog2(RAS_DEPTH)+1  current stack occupancy
O_Err  out  1  sticky stack overflow/underflow

Behaviour:
- Reset: state IDLE; O_Address=0, O_IFetch=0, O_StallReq=0, O_RAS_Depth=0, O_Err=0, RAS contents don't-care.
- Req = I_Req & ~I_Stall. O_IFetch is Req registered (1-cycle latency). O_Address is registered.
- Priority per cycle: reset > I_Req_St > I_Stall > Jump > Call > Return > Branch > sequential. Lower-priority flags raised in the same cycle are ignored.
- IDLE: I_Req_St holds PC at 0. First Req moves to RUN and is processed as in RUN.
- RUN, Req with:
  - no control flag: PC+1.
  - Jump: PC=I_Src.
  - Call: push PC+1, PC=I_Src.
  - Return: PC=top, pop.
- Branch in RUN: valid only if I_Timing_MY == I_Timing_WB+1 (mod 2^TIMING_W); otherwise treated as sequential.
  - Valid and I_CondValid[I_Sel_Cond] high in the same cycle: resolve immediately. PC = PC+I_Src (mod 2^ADDR_W) if I_Cond[I_Sel_Cond], else PC+1.
  - Valid, condition not yet valid: latch channel and offset, enter WAIT.
- WAIT:
  - O_StallReq=1 (registered, asserted the cycle after entry). PC held, O_IFetch=0.
  - On I_CondValid[latched channel]: resolve as above, O_StallReq drops next cycle, return to RUN.
  - I_Req_St in WAIT aborts: PC=0, IDLE.
- I_Req_St from any state: PC=0, RAS emptied, O_Err kept, IDLE.
- All address arithmetic wraps modulo 2^ADDR_W. PC 0xFFFF+1 gives 0.
- Stack full + Call: overflow, O_Err set; handling per optional feature. Empty + Return: underflow, O_Err set; PC=PC+1 in both builds.
- Call and Return never occur together; priority covers violations.

Optional Feature:
TPU_PAC_RAS_PROTECT_EN.
- Defined: overflowing Call still jumps but the push is suppressed (depth stays RAS_DEPTH); underflow leaves depth at 0.
- Undefined: the stack pointer wraps, the oldest entry is overwritten, and depth saturates at RAS_DEPTH; underflow is as above. O_Err is sticky in both builds.

Decomposition:
- pkg_tpu gets pac_state_t (PAC_IDLE, PAC_RUN, PAC_WAIT), a parametrised pac_addr_t if not already covered by address_t, and PAC_RAS_DEPTH_DEF.
- One sub-module: tpu_pac_ras_stack (LIFO with push/pop/flush, depth and overflow/underflow outputs).

Test Plan:
- Reset, then I_Req for 4 cycles → O_IFetch rises one cycle after the first request; O_Address 0,1,2,3,4.
- PC=0x10, Branch with MY=5, WB=4, channel 2 valid and true, I_Src=0x20 → PC=0x30, O_StallReq stays 0.
- PC=0x10, Branch valid, CondValid[1] arrives 3 cycles later with Cond=0 → O_StallReq high for those cycles, PC holds 0x10 then becomes 0x11.
- Call I_Src=0x100 at PC=0x08 → PC=0x100, depth=1; Return → PC=0x09, depth=0.
- 9 Calls with RAS_DEPTH=8 → O_Err=1. Protect build: 8 Returns restore the first 8 return addresses. Non-protect build: oldest entry lost.
- I_Req_St during WAIT → PC=0, O_StallReq=0, depth=0, IDLE; next I_Req fetches address 0→1.
